// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared widths, funct3/opcode encodings and MEM-stage FSM states
package mem_access_pkg;
    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int MemBus     = 32;
    localparam int MemAddrBus = 32;
    localparam int OpcodeWide = 7;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [OpcodeWide-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OpcodeWide-1:0] OP_STORE = 7'b0100011;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT_R = 2'd2} state_e;
endpackage

// File: rtl/mem_access_lsu_align.sv
// lsu_align: store byte-enable/data formatting, load lane extract/extend, bad-access detect
// in : funct3_i/addr_lo_i/we_i/wdata_i describe the current access;
//      ld_funct3_i/ld_addr_lo_i/rdata_i describe the outstanding load
// out: be_o/wdata_o bus formatting, rdata_o extended load result, bad_o misaligned or illegal
module lsu_align
    import mem_access_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        addr_lo_i,
    input  logic              we_i,
    input  logic [RegBus-1:0] wdata_i,
    input  logic [2:0]        ld_funct3_i,
    input  logic [1:0]        ld_addr_lo_i,
    input  logic [MemBus-1:0] rdata_i,
    output logic [3:0]        be_o,
    output logic [MemBus-1:0] wdata_o,
    output logic [RegBus-1:0] rdata_o,
    output logic              bad_o
);
    logic [1:0]  size;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    assign size  = funct3_i[1:0];
    assign bad_o = funct3_i == 3'b011 || funct3_i[2:1] == 2'b11 ||
                   (size == F3_H[1:0] && addr_lo_i[0]) ||
                   (size == F3_W[1:0] && addr_lo_i != 2'b00);
    assign be_o    = !we_i ? 4'b1111 :
                     size == F3_B[1:0] ? 4'b0001 << addr_lo_i :
                     size == F3_H[1:0] ? (addr_lo_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata_o = !we_i ? '0 :
                     size == F3_B[1:0] ? {4{wdata_i[7:0]}} :
                     size == F3_H[1:0] ? {2{wdata_i[15:0]}} : wdata_i;
    assign rbyte   = 8'(rdata_i >> {ld_addr_lo_i, 3'b000});
    assign rhalf   = ld_addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    assign rdata_o = ld_funct3_i == F3_B  ? {{24{rbyte[7]}}, rbyte} :
                     ld_funct3_i == F3_BU ? {24'b0, rbyte} :
                     ld_funct3_i == F3_H  ? {{16{rhalf[15]}}, rhalf} :
                     ld_funct3_i == F3_HU ? {16'b0, rhalf} : rdata_i;
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage driving a req/gnt/rvalid data-memory bus
// in : EX/MEM results (mem_*_i, reg_*_i, opcode_i, funct3_i), bus gnt/rvalid/rdata
// out: dmem_* bus request, stall_o upstream hold, registered wb_* result and err_o pulse
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [RegBus-1:0]     mem_wdata_i,
    input  logic [MemAddrBus-1:0] mem_raddr_i,
    input  logic [MemAddrBus-1:0] mem_waddr_i,
    input  logic                  mem_we_i,
    input  logic                  mem_req_i,
    input  logic [RegBus-1:0]     reg_wdata_i,
    input  logic                  reg_we_i,
    input  logic [RegAddrBus-1:0] reg_waddr_i,
    input  logic [OpcodeWide-1:0] opcode_i,
    input  logic [2:0]            funct3_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [MemAddrBus-1:0] dmem_addr_o,
    output logic [MemBus-1:0]     dmem_wdata_o,
    output logic [3:0]            dmem_be_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [MemBus-1:0]     dmem_rdata_i,
    output logic                  stall_o,
    output logic [RegBus-1:0]     wb_wdata_o,
    output logic                  wb_we_o,
    output logic [RegAddrBus-1:0] wb_waddr_o,
    output logic                  err_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_e                  state, state_nx;
    logic [CW-1:0]           cnt;
    logic [1:0]              ld_addr_lo;
    logic [2:0]              ld_funct3;
    logic [RegAddrBus-1:0]   ld_waddr;
    logic [MemAddrBus-1:0]   addr;
    logic [3:0]              be;
    logic [MemBus-1:0]       wdata;
    logic [RegBus-1:0]       ld_data;
    logic                    bad, go, done, tout, ld_gnt, unused_op;
    // mem_req_i/mem_we_i already classify the access; opcode is carried for tracing only
    assign unused_op = (opcode_i != OP_LOAD) & (opcode_i != OP_STORE);
    assign addr = mem_we_i ? mem_waddr_i : mem_raddr_i;
    lsu_align u_align (
        .funct3_i     (funct3_i),
        .addr_lo_i    (addr[1:0]),
        .we_i         (mem_we_i),
        .wdata_i      (mem_wdata_i),
        .ld_funct3_i  (ld_funct3),
        .ld_addr_lo_i (ld_addr_lo),
        .rdata_i      (dmem_rdata_i),
        .be_o         (be),
        .wdata_o      (wdata),
        .rdata_o      (ld_data),
        .bad_o        (bad)
    );
    assign go           = mem_req_i && !bad;
    assign dmem_req_o   = state == S_REQ || (state == S_IDLE && go);
    assign dmem_we_o    = dmem_req_o && mem_we_i;
    assign dmem_addr_o  = dmem_req_o ? {addr[MemAddrBus-1:2], 2'b00} : '0;
    assign dmem_be_o    = dmem_req_o ? be : '0;
    assign dmem_wdata_o = dmem_req_o ? wdata : '0;
    assign ld_gnt = dmem_req_o && dmem_gnt_i && !mem_we_i;
    assign done   = (state == S_REQ && dmem_gnt_i && mem_we_i) || (state == S_WAIT_R && dmem_rvalid_i);
    // a completion in the last allowed cycle wins over the timeout
    assign tout   = state != S_IDLE && cnt == CW'(TIMEOUT - 1) && !done;
    assign stall_o = dmem_req_o ? !(dmem_gnt_i && mem_we_i) && !tout :
                     state == S_WAIT_R && !dmem_rvalid_i && !tout;
    assign state_nx = tout || done ? S_IDLE :
                      ld_gnt ? S_WAIT_R :
                      state == S_IDLE && go && !dmem_gnt_i ? S_REQ : state;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            ld_addr_lo <= '0;
            ld_funct3  <= '0;
            ld_waddr   <= '0;
            wb_wdata_o <= '0;
            wb_we_o    <= 1'b0;
            wb_waddr_o <= '0;
            err_o      <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= state == S_IDLE || state_nx == S_IDLE ? '0 : cnt + CW'(1);
            err_o   <= tout || (state == S_IDLE && mem_req_i && bad);
            wb_we_o <= 1'b0;
            if (ld_gnt) begin
                ld_addr_lo <= addr[1:0];
                ld_funct3  <= funct3_i;
                ld_waddr   <= reg_waddr_i;
            end
            if (state == S_IDLE && !mem_req_i) begin
                wb_wdata_o <= reg_wdata_i;
                wb_we_o    <= reg_we_i;
                wb_waddr_o <= reg_waddr_i;
            end else if (state == S_WAIT_R && dmem_rvalid_i) begin
                wb_wdata_o <= ld_data;
                wb_we_o    <= reg_we_i;
                wb_waddr_o <= ld_waddr;
            end
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: table-driven and randomized checks of mem_access against a byte-level model
module tb_mem_access;
    import mem_access_pkg::*;
    localparam int TO = 6;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] mem_wdata_i = '0, mem_raddr_i = '0, mem_waddr_i = '0;
    logic        mem_we_i = 1'b0, mem_req_i = 1'b0;
    logic [31:0] reg_wdata_i = '0;
    logic        reg_we_i = 1'b0;
    logic [4:0]  reg_waddr_i = '0;
    logic [6:0]  opcode_i = '0;
    logic [2:0]  funct3_i = '0;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        stall_o, wb_we_o, err_o;
    logic [31:0] wb_wdata_o;
    logic [4:0]  wb_waddr_o;
    int total = 0, passed = 0;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .mem_wdata_i(mem_wdata_i), .mem_raddr_i(mem_raddr_i),
        .mem_waddr_i(mem_waddr_i), .mem_we_i(mem_we_i), .mem_req_i(mem_req_i),
        .reg_wdata_i(reg_wdata_i), .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i),
        .opcode_i(opcode_i), .funct3_i(funct3_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .stall_o(stall_o), .wb_wdata_o(wb_wdata_o), .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o),
        .err_o(err_o)
    );

    typedef struct {
        int          kind;
        logic [2:0]  f3;
        logic [31:0] addr, data, rdata;
        int          g, r;
        logic [31:0] reg_d;
        logic        rwe;
        logic [4:0]  rad;
        bit          bad, stray;
        logic [3:0]  ebe;
        logic [31:0] ewd, eres;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_bad(input logic [2:0] f3, input logic [31:0] a);
        return f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (int'(a[1:0]) % nbytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int n = nbytes(f3);
        return 4'(((1 << n) - 1) << (int'(a[1:0]) / n * n));
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w = '0;
        int n = nbytes(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int n = nbytes(f3);
        logic [31:0] v = rd >> (8 * (int'(a[1:0]) / n * n));
        logic [31:0] mask = n == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
        v &= mask;
        if (!f3[2] && v[8*n-1]) v |= ~mask;
        return v;
    endfunction

    function automatic vec_t mv(input int kind, input logic [2:0] f3, input logic [31:0] addr, data, rdata,
                                input int g, r, input logic [31:0] reg_d, input logic rwe, input logic [4:0] rad,
                                input bit bad, input logic [3:0] ebe, input logic [31:0] ewd, eres);
        vec_t v;
        v.kind = kind; v.f3 = f3; v.addr = addr; v.data = data; v.rdata = rdata; v.g = g; v.r = r;
        v.reg_d = reg_d; v.rwe = rwe; v.rad = rad; v.bad = bad; v.stray = 1'b0;
        v.ebe = ebe; v.ewd = ewd; v.eres = eres;
        return v;
    endfunction

    task automatic run(input vec_t v, input string tag);
        bit mem = v.kind != 0, ld = v.kind == 2, tmo, req;
        int e = (v.kind == 0 || v.bad) ? 0 : (ld ? v.g + v.r : v.g);
        logic we_exp;
        tmo = e > TO;
        if (tmo) e = TO;
        for (int c = 0; c <= e; c++) begin
            @(negedge clk);
            if (c == 0) begin
                mem_req_i = mem;
                mem_we_i = v.kind == 1;
                mem_waddr_i = ld ? $urandom : v.addr;
                mem_raddr_i = ld ? v.addr : $urandom;
                mem_wdata_i = v.data;
                funct3_i = v.f3;
                opcode_i = ld ? OP_LOAD : mem ? OP_STORE : 7'b0110011;
                reg_wdata_i = v.reg_d;
                reg_we_i = v.rwe;
                reg_waddr_i = v.rad;
            end
            dmem_gnt_i = mem && !v.bad && c == v.g;
            dmem_rvalid_i = v.kind == 0 ? v.stray : ld && !v.bad && c == v.g + v.r;
            dmem_rdata_i = v.rdata;
            #1;
            req = mem && !v.bad && c <= v.g;
            check($sformatf("%s c%0d stall", tag, c), 32'(stall_o), 32'(c < e));
            check($sformatf("%s c%0d req", tag, c), 32'(dmem_req_o), 32'(req));
            if (req) begin
                check($sformatf("%s c%0d addr", tag, c), dmem_addr_o, {v.addr[31:2], 2'b00});
                check($sformatf("%s c%0d we", tag, c), 32'(dmem_we_o), 32'(v.kind == 1));
                check($sformatf("%s c%0d be", tag, c), 32'(dmem_be_o), 32'(v.ebe));
                check($sformatf("%s c%0d wdata", tag, c), dmem_wdata_o, v.ewd);
            end
            if (v.kind == 0) check($sformatf("%s idle be", tag), 32'(dmem_be_o), 32'h0);
        end
        @(posedge clk);
        #1;
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b0;
        we_exp = (v.kind == 0 || (ld && !tmo && !v.bad)) ? v.rwe : 1'b0;
        check({tag, " err"}, 32'(err_o), 32'(v.bad || tmo));
        check({tag, " wb_we"}, 32'(wb_we_o), 32'(we_exp));
        if (we_exp) begin
            check({tag, " wb_wdata"}, wb_wdata_o, v.kind == 0 ? v.reg_d : v.eres);
            check({tag, " wb_waddr"}, 32'(wb_waddr_o), 32'(v.rad));
        end
    endtask

    vec_t tbl[16];
    vec_t rv;

    initial begin
        tbl[0]  = mv(0, 3'b000, 0, 0, 0, 0, 1, 32'h1234, 1, 5, 0, 0, 0, 0);
        tbl[1]  = mv(1, F3_B, 32'h103, 32'hAB, 0, 0, 1, 0, 1, 4, 0, 4'b1000, 32'hABABABAB, 0);
        tbl[2]  = mv(2, F3_H, 32'h202, 0, 32'h8001_0000, 2, 3, 0, 1, 7, 0, 4'b1111, 0, 32'hFFFF8001);
        tbl[3]  = mv(2, F3_HU, 32'h202, 0, 32'h8001_0000, 2, 3, 0, 1, 8, 0, 4'b1111, 0, 32'h00008001);
        tbl[4]  = mv(2, F3_W, 32'h105, 0, 0, 0, 1, 0, 1, 2, 1, 0, 0, 0);
        tbl[5]  = mv(2, 3'b011, 32'h100, 0, 0, 0, 1, 0, 1, 2, 1, 0, 0, 0);
        tbl[6]  = mv(1, F3_H, 32'h101, 32'h1234_5678, 0, 0, 1, 0, 1, 2, 1, 0, 0, 0);
        tbl[7]  = mv(1, F3_H, 32'h102, 32'h1234_5678, 0, 1, 1, 0, 1, 2, 0, 4'b1100, 32'h56785678, 0);
        tbl[8]  = mv(1, F3_W, 32'h200, 32'hDEADBEEF, 0, 0, 1, 0, 1, 2, 0, 4'b1111, 32'hDEADBEEF, 0);
        tbl[9]  = mv(1, F3_B, 32'h0, 32'h5A, 0, 3, 1, 0, 1, 2, 0, 4'b0001, 32'h5A5A5A5A, 0);
        tbl[10] = mv(2, F3_B, 32'h301, 0, 32'h1122_8344, 0, 1, 0, 1, 11, 0, 4'b1111, 0, 32'hFFFFFF83);
        tbl[11] = mv(2, F3_BU, 32'h301, 0, 32'h1122_8344, 1, 2, 0, 1, 12, 0, 4'b1111, 0, 32'h00000083);
        tbl[12] = mv(2, F3_W, 32'h10, 0, 32'hCAFE_0001, 0, 2, 0, 1, 0, 0, 4'b1111, 0, 32'hCAFE0001);
        tbl[13] = mv(2, F3_W, 32'h400, 0, 32'h1, 0, 20, 0, 1, 3, 0, 4'b1111, 0, 0);
        tbl[14] = mv(0, 3'b000, 0, 0, 32'h9999, 0, 1, 32'h77, 1, 12, 0, 0, 0, 0);
        tbl[14].stray = 1'b1;
        tbl[15] = mv(1, F3_W, 32'h44, 32'h0BAD_F00D, 0, 20, 1, 0, 1, 2, 0, 4'b1111, 32'h0BADF00D, 0);

        #1;
        check("reset stall", 32'(stall_o), 0);
        check("reset req", 32'(dmem_req_o), 0);
        check("reset be", 32'(dmem_be_o), 0);
        check("reset wb_we", 32'(wb_we_o), 0);
        check("reset wb_wdata", wb_wdata_o, 0);
        check("reset err", 32'(err_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run(tbl[i], $sformatf("vec%0d", i));

        // reset dropped while a load sits in WAIT_R
        run(mv(0, 3'b000, 0, 0, 0, 0, 1, 32'h5555AAAA, 1, 9, 0, 0, 0, 0), "pre_rst");
        @(negedge clk);
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_raddr_i = 32'h40; funct3_i = F3_W;
        reg_we_i = 1'b1; reg_waddr_i = 5'd3; dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b0;
        @(negedge clk);
        dmem_gnt_i = 1'b0;
        #1;
        check("wait stall", 32'(stall_o), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        mem_req_i = 1'b0;
        #1;
        check("rst stall", 32'(stall_o), 0);
        check("rst req", 32'(dmem_req_o), 0);
        check("rst addr", dmem_addr_o, 0);
        check("rst wb_wdata", wb_wdata_o, 0);
        check("rst wb_waddr", 32'(wb_waddr_o), 0);
        check("rst err", 32'(err_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(mv(2, F3_H, 32'h42, 0, 32'hABCD_1234, 1, 1, 0, 1, 6, 0, 4'b1111, 0, 32'hFFFFABCD), "post_rst");

        for (int i = 0; i < 60; i++) begin
            rv.kind = $urandom_range(0, 2);
            rv.f3 = rv.kind == 1 ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            rv.addr = $urandom;
            rv.data = $urandom;
            rv.rdata = $urandom;
            rv.g = $urandom_range(0, 3);
            rv.r = $urandom_range(1, 4);
            rv.reg_d = $urandom;
            rv.rwe = 1'($urandom);
            rv.rad = 5'($urandom);
            rv.stray = 1'b0;
            rv.bad = rv.kind != 0 && m_bad(rv.f3, rv.addr);
            rv.ebe = rv.kind == 2 ? 4'b1111 : rv.bad ? 4'b0 : m_be(rv.f3, rv.addr);
            rv.ewd = rv.kind == 1 && !rv.bad ? m_wd(rv.f3, rv.data) : 32'h0;
            rv.eres = rv.kind == 2 && !rv.bad ? m_res(rv.f3, rv.addr, rv.rdata) : 32'h0;
            run(rv, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
